// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one step per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
module alu_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] MulDivResult
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [XLEN-1:0] ONES = '1;
    localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [2:0]        op;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   opb;
    logic              msign;
    logic              neg_q;
    logic              neg_r;

    logic              accept;
    logic              last;
    logic              is_div;
    logic              is_signed_div;
    logic              div_zero;
    logic              div_ovf;
    logic              mul_signed_a;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN-1:0]   fast_res;

    assign ready         = (state == IDLE) || (state == DONE);
    assign accept        = ready & start & ~flush;
    assign last          = (count == CNT_W'(1));
    assign is_div        = funct3[2];
    assign is_signed_div = ~funct3[0];
    assign div_zero      = (ReadData2 == '0);
    assign div_ovf       = is_signed_div & (ReadData1 == MIN) & (ReadData2 == ONES);
    assign mul_signed_a  = (funct3 == 3'b001) || (funct3 == 3'b010);
    assign abs_a         = (is_signed_div & ReadData1[XLEN-1]) ? -ReadData1 : ReadData1;
    assign abs_b         = (is_signed_div & ReadData2[XLEN-1]) ? -ReadData2 : ReadData2;

    always_comb begin
        if (div_zero) fast_res = funct3[1] ? ReadData1 : ONES;
        else          fast_res = funct3[1] ? '0 : MIN;
    end

    // Multiplier bit XLEN-1 carries negative weight for MULH, hence the subtract on the last step
    logic [2*XLEN-1:0] mul_next;
    always_comb begin
        mul_next = acc;
        if (opb[0]) mul_next = (last && msign) ? acc - mcand : acc + mcand;
    end

    // acc holds {remainder, dividend/quotient}; one restoring step per cycle
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    always_comb begin
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (!div_diff[XLEN]) begin
            rem_next = div_diff[XLEN-1:0];
            quo_next = {acc[XLEN-2:0], 1'b1};
        end else begin
            rem_next = div_shift[XLEN-1:0];
            quo_next = {acc[XLEN-2:0], 1'b0};
        end
    end

    logic [XLEN-1:0] mul_res;
    logic [XLEN-1:0] div_res;
    assign mul_res = (op == 3'b000) ? mul_next[XLEN-1:0] : mul_next[2*XLEN-1:XLEN];
    assign div_res = op[1] ? (neg_r ? -rem_next : rem_next)
                           : (neg_q ? -quo_next : quo_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            op           <= '0;
            acc          <= '0;
            mcand        <= '0;
            opb          <= '0;
            msign        <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            MulDivResult <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (accept) begin
                        op    <= funct3;
                        count <= CNT_W'(XLEN);
                        if (!is_div) begin
                            state <= MUL;
                            busy  <= 1'b1;
                            acc   <= '0;
                            mcand <= mul_signed_a ? {{XLEN{ReadData1[XLEN-1]}}, ReadData1}
                                                  : {{XLEN{1'b0}}, ReadData1};
                            opb   <= ReadData2;
                            msign <= (funct3 == 3'b001);
                        end else if (div_zero || div_ovf) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            MulDivResult <= fast_res;
                        end else begin
                            state <= DIV;
                            busy  <= 1'b1;
                            acc   <= {{XLEN{1'b0}}, abs_a};
                            opb   <= abs_b;
                            neg_q <= is_signed_div & (ReadData1[XLEN-1] ^ ReadData2[XLEN-1]);
                            neg_r <= is_signed_div & ReadData1[XLEN-1];
                        end
                    end
                end
                MUL, DIV: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc   <= (state == MUL) ? mul_next : {rem_next, quo_next};
                        mcand <= mcand << 1;
                        if (state == MUL) opb <= opb >> 1;
                        count <= count - CNT_W'(1);
                        if (last) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            MulDivResult <= (state == MUL) ? mul_res : div_res;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed RV32M cases plus random operations
// compared against a 64-bit arithmetic reference model.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] MulDivResult;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] MIN  = 32'h8000_0000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    alu_muldiv_seq #(.XLEN(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .flush(flush),
        .funct3(funct3),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2),
        .ready(ready),
        .busy(busy),
        .done(done),
        .MulDivResult(MulDivResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics computed with wide plain arithmetic
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int          ia;
        int          ib;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return ONES;
                if (a == MIN && b == ONES) return MIN;
                return ia / ib;
            end
            3'd5: return (b == 0) ? ONES : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == ONES) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int expLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == MIN && b == ONES))) return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct3    = f3;
        ReadData1 = a;
        ReadData2 = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        funct3    = 3'($urandom);
        ReadData1 = $urandom;
        ReadData2 = $urandom;
    endtask

    // Starts at the falling edge of cycle 1 and waits (bounded) for the done pulse
    task automatic awaitResult(input string tag, input logic [31:0] expRes, input int expLat, input logic [31:0] prevRes);
        int cyc = 1;
        int busyCycles = 0;
        logic stable = 1'b1;
        while (done !== 1'b1 && cyc <= 100) begin
            if (busy === 1'b1) busyCycles++;
            if (MulDivResult !== prevRes) stable = 1'b0;
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(expLat));
        checkOutput({tag, "_result"}, MulDivResult, expRes);
        checkOutput({tag, "_busy_cycles"}, 32'(busyCycles), 32'(expLat - 1));
        checkOutput({tag, "_held"}, {31'b0, stable}, 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] prevRes;
        prevRes = MulDivResult;
        applyStimulus(f3, a, b);
        awaitResult(tag, refModel(f3, a, b), expLatency(f3, a, b), prevRes);
    endtask

    initial begin
        logic [31:0] prevRes;
        logic        sawDone;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        funct3 = 3'b0;
        ReadData1 = '0;
        ReadData2 = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", MulDivResult, 32'd0);
        checkOutput("reset_ready", {31'b0, ready}, 32'd1);
        rst_n = 1'b1;

        runOp("mul_7xm3", 3'b000, 32'd7, 32'hFFFF_FFFD);
        runOp("mulh_min", 3'b001, MIN, MIN);
        runOp("mulhu_min", 3'b011, MIN, MIN);
        runOp("mulhsu_m1x2", 3'b010, ONES, 32'd2);
        runOp("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2);
        runOp("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2);
        runOp("divu_100_7", 3'b101, 32'd100, 32'd7);
        runOp("remu_100_7", 3'b111, 32'd100, 32'd7);
        runOp("divu_by0", 3'b101, 32'd5, 32'd0);
        runOp("rem_by0", 3'b110, 32'd5, 32'd0);
        runOp("div_ovf", 3'b100, MIN, ONES);
        runOp("rem_ovf", 3'b110, MIN, ONES);

        for (int i = 0; i < 30; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 7 == 3) rb = 32'd0;
            if (i % 7 == 5) begin ra = MIN; rb = ONES; end
            if (i % 7 == 6) rb = 32'($urandom_range(1, 15));
            runOp($sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb);
        end

        // Flush a multiply in cycle 10
        prevRes = MulDivResult;
        applyStimulus(3'b000, 32'd1234, 32'd5678);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("flush_ready", {31'b0, ready}, 32'd1);
        sawDone = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("flush_no_done", {31'b0, sawDone}, 32'd0);
        checkOutput("flush_result_kept", MulDivResult, prevRes);

        // start together with flush in IDLE is not accepted
        funct3    = 3'b000;
        ReadData1 = 32'd3;
        ReadData2 = 32'd4;
        start     = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        checkOutput("start_flush_busy", {31'b0, busy}, 32'd0);
        sawDone = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("start_flush_no_done", {31'b0, sawDone}, 32'd0);
        checkOutput("start_flush_result_kept", MulDivResult, prevRes);

        // Asynchronous reset in cycle 15 of a divide
        applyStimulus(3'b100, 32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset_done", {31'b0, done}, 32'd0);
        checkOutput("midreset_result", MulDivResult, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postreset_ready", {31'b0, ready}, 32'd1);

        // Back-to-back DIVU then MUL with start held through the DIVU
        prevRes = MulDivResult;
        @(negedge clk);
        funct3    = 3'b101;
        ReadData1 = 32'd1000;
        ReadData2 = 32'd9;
        start     = 1'b1;
        @(negedge clk);
        funct3    = 3'b000;
        ReadData1 = 32'd12345;
        ReadData2 = 32'd678;
        awaitResult("b2b_divu", refModel(3'b101, 32'd1000, 32'd9), 33, prevRes);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_no_bubble_busy", {31'b0, busy}, 32'd1);
        checkOutput("b2b_no_bubble_done", {31'b0, done}, 32'd0);
        awaitResult("b2b_mul", refModel(3'b000, 32'd12345, 32'd678), 33, refModel(3'b101, 32'd1000, 32'd9));

        @(negedge clk);
        checkOutput("final_done_low", {31'b0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle integer ALU, adding the RV32M multiply/divide operations.
- Sits beside the combinational ALU in the execute stage: the control unit launches an operation with a start pulse and stalls the pipeline while busy.
- Iterative radix-2 datapath: one shift/add or shift/subtract step per cycle.
- Fast paths for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand and result width in bits; must be even and >= 8.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  launch request; sampled only while ready=1.
- flush  input  1  synchronous abort of any in-flight operation.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ReadData1  input  XLEN  rs1 operand (dividend / multiplicand).
- ReadData2  input  XLEN  rs2 operand (divisor / multiplier).
- ready  output  1  high in IDLE or DONE; start is accepted only when high.
- busy  output  1  high while the FSM is in MUL or DIV.
- done  output  1  one-cycle pulse; MulDivResult is valid in this cycle.
- MulDivResult  output  XLEN  result; held until the next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, MulDivResult=0, counter=0, internal registers cleared. This holds in any state, including mid-operation.
- FSM states: IDLE, MUL, DIV, DONE.
- Acceptance: the edge at which ready=1 and start=1 and flush=0. At that edge funct3 and both operands are latched; later input changes have no effect.
- Cycle numbering: cycle 1 is the cycle immediately after the acceptance edge.
- Transitions:
  - IDLE/DONE + accept, funct3[2]=0 -> MUL.
  - IDLE/DONE + accept, funct3[2]=1, no fast path -> DIV.
  - IDLE/DONE + accept, fast path -> DONE.
  - DONE without accept -> IDLE.
  - MUL/DIV -> DONE at the edge ending the XLEN-th iteration cycle.
- Latency:
  - Normal operations: iteration cycles 1..XLEN, done=1 in cycle XLEN+1.
  - Fast paths: done=1 in cycle 1.
- Back-to-back: start accepted during the DONE cycle is legal. No idle bubble is inserted.
- start while busy=1: ignored; no queueing.
- Multiply:
  - Operands are extended to XLEN+1 bits: signed for MULH (both), MULHSU (rs1 only); unsigned otherwise.
  - Booth-free shift-add over a 2*XLEN product. The signed correction for the multiplier MSB is applied in the final iteration (subtract instead of add).
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - DIV/REM: absolute values are taken at acceptance. Restoring divide runs on magnitudes.
  - Sign fixup at DONE entry: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - DIVU/REMU: no sign handling.
- Fast path, divisor=0: DIV/DIVU -> all ones; REM/REMU -> ReadData1.
- Fast path, signed overflow: DIV or REM with ReadData1=100..0 and ReadData2=all ones. DIV -> 100..0; REM -> 0.
- MulDivResult: updated only on the edge entering DONE; stable at all other times.
- done: high only in the DONE state, exactly one cycle per operation. Never asserted for flushed operations.
- flush:
  - In MUL/DIV: at the next edge the FSM returns to IDLE, done stays 0, MulDivResult keeps its previous value.
  - flush has priority over start in the same cycle.
  - flush in IDLE/DONE only forces the next state to IDLE.
- Counter: loaded with XLEN on acceptance, decremented once per iteration. It never wraps, because the transition to DONE happens at count 1.

Test Plan:
- XLEN=32, MUL with 7 and 0xFFFFFFFD -> done in cycle 33 exactly, MulDivResult=0xFFFFFFEB; busy=1 in cycles 1..32.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU on the same operands -> 0x40000000. MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF. DIVU 100/7 -> 14 and REMU -> 2, each done in cycle 33.
- DIVU 5/0 -> done in cycle 1, result 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> done in cycle 1, result 0x80000000; REM on the same operands -> 0.
- Start MUL, assert flush in cycle 10 -> IDLE next cycle, no done pulse, MulDivResult unchanged. Start plus flush in the same cycle in IDLE -> not accepted.
- Drop rst_n mid-DIV (cycle 15) -> all outputs 0 immediately. Next, issue back-to-back DIVU then MUL with start held during DONE -> two done pulses with no idle cycle between the operations.
